dmem_responder: RTL and testbench

- Data-memory responder on the far end of the CPU datapath's M-stage load/store interface.
- Accepts one word-addressed request at a time: byte-enable write or full-word read.
- Holds storage in an internal word array and returns read data after a programmable latency.
- Drives a stall line so the pipeline can freeze while a request is outstanding; with LATENCY=1 it behaves as the single-cycle RAM the pipeline expects today.

---
 rtl/dmem_responder_if.sv | 38 +++
 rtl/dmem_responder.sv | 154 +++++++++++++++
 tb/tb_dmem_responder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the M-stage load/store port and the data-memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    // CPU side: issues requests and consumes responses.
    modport master (
        output req_valid,
        output req_wen,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err,
        input  stall
    );

    // Memory side: accepts requests and produces responses.
    modport slave (
        input  req_valid,
        input  req_wen,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err,
        output stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word array with byte-enable writes, full-word reads and a
// programmable response latency. One request outstanding at a time; stall covers the
// wait cycles so the pipeline can freeze. LATENCY=1 gives single-cycle RAM behaviour.
module dmem_responder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [31:0] SPAN     = 32'(DEPTH) << 2;
    // BUSY lasts LATENCY-1 cycles, so the counter is loaded with LATENCY-2 and ends at 0.
    localparam logic [3:0]  LAT_LOAD = (LATENCY >= 32'd2) ? 4'(LATENCY - 32'd2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_next_s;
    logic              ready_r;
    logic              valid_r;
    logic              stall_r;
    logic              ready_s;
    logic              valid_s;
    logic              stall_s;
    logic [31:0]       rdata_r;
    logic              err_r;
    logic [31:0]       offset_s;
    logic              in_range_s;
    logic              wen_ok_s;
    logic              req_err_s;
    logic              accept_s;
    logic              do_write_s;
    logic [ADDR_W-1:0] idx_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       mem_r [0:DEPTH-1];

    // Only single bytes, aligned halves and the full word are legal store shapes.
    function automatic logic wen_legal(input logic [3:0] wen);
        case (wen)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100, 4'b1111: wen_legal = 1'b1;
            default:                            wen_legal = 1'b0;
        endcase
    endfunction

    // Request decode: range check on the 32-bit offset happens before indexing, so no wrap.
    always_comb begin
        offset_s   = bus.req_addr - BASE_ADDR;
        in_range_s = (offset_s < SPAN);
        wen_ok_s   = wen_legal(bus.req_wen);
        req_err_s  = ~(in_range_s & wen_ok_s);
        accept_s   = bus.req_valid & ready_r & ~rst;
        idx_s      = offset_s[ADDR_W+1:2];
        do_write_s = accept_s & ~req_err_s & (bus.req_wen != 4'b0000);
        rd_word_s  = mem_r[idx_s];
    end

    // Next-state logic: IDLE and RESP both accept, which allows back-to-back requests.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE, ST_RESP: begin
                if (accept_s) begin
                    if (LATENCY == 32'd1) begin
                        state_next_s = ST_RESP;
                    end else begin
                        state_next_s = ST_BUSY;
                        cnt_next_s   = LAT_LOAD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_RESP;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so the handshake outputs can be registered.
    always_comb begin
        ready_s = (state_next_s != ST_BUSY);
        stall_s = (state_next_s == ST_BUSY);
        valid_s = (state_next_s == ST_RESP);
    end

    // State, counter and handshake output registers; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            stall_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            ready_r <= ready_s;
            valid_r <= valid_s;
            stall_r <= stall_s;
        end
    end

    // Response hold register: captured at acceptance and held until the next acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else if (accept_s) begin
            err_r   <= req_err_s;
            rdata_r <= (req_err_s || (bus.req_wen != 4'b0000)) ? 32'h0000_0000 : rd_word_s;
        end else begin
            rdata_r <= rdata_r;
            err_r   <= err_r;
        end
    end

    // Storage array: enabled bytes commit on the acceptance edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.req_wen[b]) begin
                    mem_r[idx_s][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = ready_r;
    assign bus.resp_valid = valid_r;
    assign bus.resp_rdata = rdata_r;
    assign bus.resp_err   = err_r;
    assign bus.stall      = stall_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: four instances (LATENCY 1, 4, 2, 5) share one
// driver; expected responses are queued at acceptance and popped by a monitor.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        drv_valid;
    logic [3:0]  drv_wen;
    logic [31:0] drv_addr;
    logic [31:0] drv_wdata;
    int          drv_sel;
    int          cyc = 0;

    logic [3:0]  valid_a;
    logic [3:0]  ready_a;
    logic [3:0]  err_a;
    logic [3:0]  stall_a;
    logic [31:0] rdata_a [4];

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   resp_cyc [4];
    int   prev_cyc [4];
    bit   stall_seen0 = 1'b0;

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to time response spacing.
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        dmem_responder_if bus ();
        assign bus.req_valid = drv_valid && (drv_sel == k);
        assign bus.req_wen   = drv_wen;
        assign bus.req_addr  = drv_addr;
        assign bus.req_wdata = drv_wdata;
        assign valid_a[k]    = bus.resp_valid;
        assign ready_a[k]    = bus.req_ready;
        assign err_a[k]      = bus.resp_err;
        assign stall_a[k]    = bus.stall;
        assign rdata_a[k]    = bus.resp_rdata;
        dmem_responder #(
            .ADDR_W   (10),
            .LATENCY  ((k == 0) ? 1 : (k == 1) ? 4 : (k == 2) ? 2 : 5),
            .BASE_ADDR(32'h0000_0000)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic monitor_step();
        exp_t e;
        if (stall_a[0] === 1'b1) stall_seen0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (valid_a[k] === 1'b1) begin
                prev_cyc[k] = resp_cyc[k];
                resp_cyc[k] = cyc;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_resp dut%0d: got resp_valid, expected none", k);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("resp_dut%0d", k), 32'(k), 32'(e.dut));
                    check($sformatf("resp_rdata_dut%0d", k), rdata_a[k], e.rdata);
                    check($sformatf("resp_err_dut%0d", k), {31'd0, err_a[k]}, {31'd0, e.err});
                end
            end
        end
    endtask

    task automatic issue(input int sel, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_rd,
                         input logic exp_err, input bit push = 1'b1);
        int waited = 0;
        drv_sel   = sel;
        drv_wen   = wen;
        drv_addr  = addr;
        drv_wdata = data;
        drv_valid = 1'b1;
        while (ready_a[sel] !== 1'b1 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (ready_a[sel] !== 1'b1) begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout dut%0d: got ready=%b, expected 1", sel, ready_a[sel]);
            drv_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) exp_q.push_back(exp_t'{sel, exp_rd, exp_err});
            #1;
        end
    endtask

    task automatic idle();
        drv_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_tests();
        int w;
        // Reset state of every instance.
        rst = 1'b1;
        drv_valid = 1'b0;
        drv_sel = 0;
        drv_wen = 4'b0000;
        drv_addr = 32'h0;
        drv_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_ready%0d", k), {31'd0, ready_a[k]}, 32'd1);
            check($sformatf("rst_valid%0d", k), {31'd0, valid_a[k]}, 32'd0);
            check($sformatf("rst_stall%0d", k), {31'd0, stall_a[k]}, 32'd0);
            check($sformatf("rst_err%0d", k), {31'd0, err_a[k]}, 32'd0);
            check($sformatf("rst_rdata%0d", k), rdata_a[k], 32'd0);
        end

        // LATENCY=1: full-word write then back-to-back read of the same word.
        issue(0, 4'b1111, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        @(negedge clk);
        check("l1_wr_valid", {31'd0, valid_a[0]}, 32'd1);
        issue(0, 4'b0000, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        idle();
        @(negedge clk);
        check("l1_rd_valid", {31'd0, valid_a[0]}, 32'd1);
        @(negedge clk);
        check("l1_valid_pulse", {31'd0, valid_a[0]}, 32'd0);
        check("l1_rdata_hold", rdata_a[0], 32'hDEAD_BEEF);

        // Byte and half-word merges into a preloaded word.
        issue(0, 4'b1111, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
        issue(0, 4'b0100, 32'h20, 32'h00AA_0000, 32'h0, 1'b0);
        issue(0, 4'b0011, 32'h20, 32'h0000_BBCC, 32'h0, 1'b0);
        issue(0, 4'b0000, 32'h20, 32'h0, 32'h11AA_BBCC, 1'b0);
        idle();
        wait_cycles(2);

        // Errors: out-of-range and illegal byte enables leave storage untouched.
        issue(0, 4'b0000, 32'h1000, 32'h0, 32'h0, 1'b1);
        issue(0, 4'b1111, 32'h0, 32'h0BAD_F00D, 32'h0, 1'b0);
        issue(0, 4'b0101, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        issue(0, 4'b0110, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        issue(0, 4'b1111, 32'h1000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        issue(0, 4'b0000, 32'h0, 32'h0, 32'h0BAD_F00D, 1'b0);
        issue(0, 4'b1111, 32'hFFC, 32'hCAFE_0FFC, 32'h0, 1'b0);
        issue(0, 4'b0000, 32'hFFC, 32'h0, 32'hCAFE_0FFC, 1'b0);
        issue(0, 4'b0000, 32'h13, 32'h0, 32'hDEAD_BEEF, 1'b0);
        idle();
        wait_cycles(2);

        // LATENCY=4: stall/ready timing with the request held through BUSY.
        issue(1, 4'b1111, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0);
        idle();
        wait_cycles(6);
        issue(1, 4'b0000, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("l4_stall_c%0d", i), {31'd0, stall_a[1]}, 32'd1);
            check($sformatf("l4_ready_c%0d", i), {31'd0, ready_a[1]}, 32'd0);
            check($sformatf("l4_valid_c%0d", i), {31'd0, valid_a[1]}, 32'd0);
        end
        @(negedge clk);
        check("l4_resp_valid", {31'd0, valid_a[1]}, 32'd1);
        check("l4_resp_stall", {31'd0, stall_a[1]}, 32'd0);
        idle();
        @(negedge clk);
        check("l4_valid_pulse", {31'd0, valid_a[1]}, 32'd0);

        // LATENCY=2: second read accepted in the RESP cycle of the first.
        issue(2, 4'b1111, 32'h40, 32'hA5A5_0001, 32'h0, 1'b0);
        issue(2, 4'b1111, 32'h44, 32'h5A5A_0002, 32'h0, 1'b0);
        idle();
        wait_cycles(4);
        issue(2, 4'b0000, 32'h40, 32'h0, 32'hA5A5_0001, 1'b0);
        issue(2, 4'b0000, 32'h44, 32'h0, 32'h5A5A_0002, 1'b0);
        idle();
        wait_cycles(4);
        check("l2_b2b_gap", 32'(resp_cyc[2] - prev_cyc[2]), 32'd2);

        // LATENCY=5: reset during BUSY drops the response but keeps the write.
        issue(3, 4'b1111, 32'h60, 32'h0000_0055, 32'h0, 1'b0, 1'b0);
        idle();
        wait_cycles(2);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check("l5_rst_ready", {31'd0, ready_a[3]}, 32'd1);
        check("l5_rst_stall", {31'd0, stall_a[3]}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("l5_no_resp_c%0d", i), {31'd0, valid_a[3]}, 32'd0);
            @(negedge clk);
        end
        issue(3, 4'b0000, 32'h60, 32'h0, 32'h0000_0055, 1'b0);
        idle();

        // Drain the scoreboard and close out the LATENCY=1 stall observation.
        w = 0;
        while (exp_q.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("l1_stall_never", {31'd0, stall_seen0}, 32'd0);
    endtask

    // Monitor, stimulus and a global watchdog run side by side; the first to end closes the run.
    initial begin
        for (int k = 0; k < 4; k++) begin
            resp_cyc[k] = 0;
            prev_cyc[k] = 0;
        end
        fork
            begin
                forever begin
                    @(negedge clk);
                    monitor_step();
                end
            end
            begin
                run_tests();
            end
            begin
                #500000;
                n_vec++;
                n_miss++;
                $display("FAIL global_timeout: got no completion, expected run to end");
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
